// File: rtl/riscv_mem_pkg.sv
// Shared MEM-stage encodings: access sizes, load/store funct3 codes, MemRW bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package riscv_mem_pkg;

    localparam logic [1:0] DSIZE_B = 2'b00;
    localparam logic [1:0] DSIZE_H = 2'b01;
    localparam logic [1:0] DSIZE_W = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int MEMRW_LD = 1;
    localparam int MEMRW_ST = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // Halves need an even address, words a 4-byte aligned one; an unknown size is checked as a word.
    function automatic logic is_misaligned(input logic [1:0] dsize, input logic [1:0] addr_lo);
        case (dsize)
            DSIZE_B: return 1'b0;
            DSIZE_H: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting: store replication/strobes and load lane select with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] st_data,
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_dsize,
    input  logic        st_is_store,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_rdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    output logic [31:0] ld_data
);

    logic [31:0] lane;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_dsize)
            DSIZE_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            DSIZE_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << {st_addr_lo[1], 1'b0};
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!st_is_store) begin
            st_wstrb = 4'b0000;
        end
    end

    always_comb begin
        lane = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  ld_data = {24'h0, lane[7:0]};
            F3_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  ld_data = {16'h0, lane[15:0]};
            F3_LW:   ld_data = lane;
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32 MEM stage: runs one data-memory req/ack transaction per load/store and fills MEM/WB.
// Latency: 1 cycle for non-memory ops; loads/stores complete on the ack edge (min 2 cycles).
// Backpressure: mem_stall holds upstream while a request is outstanding; released by ack or timeout.
module mem_access
    import riscv_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic [2:0]  writeback_control_pype2,
    input  logic [31:0] PCp4_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        mem_bus_err,
    output logic [31:0] mem_fault_addr,
    output logic [31:0] load_data_pype3,
    output logic [31:0] ALU_co_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [2:0]  writeback_control_pype3,
    output logic [31:0] PCp4_pype3
);

    localparam logic [TMO_W:0] TMO_LIM = (TMO_W + 1)'(ACK_TIMEOUT);

    mem_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  wreg_lat_q, wreg_lat_d;
    logic [2:0]  wbc_lat_q, wbc_lat_d;
    logic [31:0] pcp4_lat_q, pcp4_lat_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [31:0] alu_p3_q, alu_p3_d;
    logic [4:0]  wreg_p3_q, wreg_p3_d;
    logic [2:0]  wbc_p3_q, wbc_p3_d;
    logic [31:0] pcp4_p3_q, pcp4_p3_d;

    logic        is_ld, is_st, access, misal, tmo_hit, stall;
    logic [31:0] fmt_wdata, fmt_rdata;
    logic [3:0]  fmt_wstrb;

    // MemRW=11 is a load, so the store bit only counts when the load bit is clear.
    assign is_ld   = MemRW_pype2[MEMRW_LD];
    assign is_st   = MemRW_pype2[MEMRW_ST] & ~is_ld;
    assign access  = is_ld | is_st;
    assign misal   = is_misaligned(dsize_pype2, ALU_co_pype[1:0]);
    assign tmo_hit = (ACK_TIMEOUT != 0) && (({1'b0, tmo_cnt_q} + (TMO_W + 1)'(1)) == TMO_LIM);

    mem_lane_align u_lane (
        .st_data     (read_data2_pype2),
        .st_addr_lo  (ALU_co_pype[1:0]),
        .st_dsize    (dsize_pype2),
        .st_is_store (is_st),
        .st_wdata    (fmt_wdata),
        .st_wstrb    (fmt_wstrb),
        .ld_rdata    (dmem_rdata),
        .ld_addr_lo  (addr_q[1:0]),
        .ld_funct3   (funct3_q),
        .ld_data     (fmt_rdata)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        funct3_d     = funct3_q;
        wreg_lat_d   = wreg_lat_q;
        wbc_lat_d    = wbc_lat_q;
        pcp4_lat_d   = pcp4_lat_q;
        tmo_cnt_d    = tmo_cnt_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        fault_addr_d = fault_addr_q;
        ld_data_d    = ld_data_q;
        alu_p3_d     = alu_p3_q;
        wreg_p3_d    = wreg_p3_q;
        wbc_p3_d     = wbc_p3_q;
        pcp4_p3_d    = pcp4_p3_q;
        stall        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!access || misal) begin
                    alu_p3_d  = ALU_co_pype;
                    wreg_p3_d = WReg_pype2;
                    wbc_p3_d  = writeback_control_pype2;
                    pcp4_p3_d = PCp4_pype2;
                    ld_data_d = 32'h0;
                    if (access) begin
                        misaligned_d = 1'b1;
                        fault_addr_d = ALU_co_pype;
                        wbc_p3_d     = 3'b000;
                    end
                end else begin
                    stall      = 1'b1;
                    req_d      = 1'b1;
                    we_d       = is_st;
                    addr_d     = ALU_co_pype;
                    wdata_d    = fmt_wdata;
                    wstrb_d    = fmt_wstrb;
                    funct3_d   = funct3_pype2;
                    wreg_lat_d = WReg_pype2;
                    wbc_lat_d  = writeback_control_pype2;
                    pcp4_lat_d = PCp4_pype2;
                    tmo_cnt_d  = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack is checked first so a response arriving on the timeout cycle is kept.
                if (dmem_ack) begin
                    req_d     = 1'b0;
                    alu_p3_d  = addr_q;
                    wreg_p3_d = wreg_lat_q;
                    wbc_p3_d  = wbc_lat_q;
                    pcp4_p3_d = pcp4_lat_q;
                    ld_data_d = we_q ? 32'h0 : fmt_rdata;
                    state_d   = ST_IDLE;
                end else if (tmo_hit) begin
                    req_d        = 1'b0;
                    bus_err_d    = 1'b1;
                    fault_addr_d = addr_q;
                    wbc_p3_d     = 3'b000;
                    state_d      = ST_IDLE;
                end else begin
                    stall     = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            funct3_q     <= 3'h0;
            wreg_lat_q   <= 5'h0;
            wbc_lat_q    <= 3'h0;
            pcp4_lat_q   <= 32'h0;
            tmo_cnt_q    <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            fault_addr_q <= 32'h0;
            ld_data_q    <= 32'h0;
            alu_p3_q     <= 32'h0;
            wreg_p3_q    <= 5'h0;
            wbc_p3_q     <= 3'h0;
            pcp4_p3_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            funct3_q     <= funct3_d;
            wreg_lat_q   <= wreg_lat_d;
            wbc_lat_q    <= wbc_lat_d;
            pcp4_lat_q   <= pcp4_lat_d;
            tmo_cnt_q    <= tmo_cnt_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            fault_addr_q <= fault_addr_d;
            ld_data_q    <= ld_data_d;
            alu_p3_q     <= alu_p3_d;
            wreg_p3_q    <= wreg_p3_d;
            wbc_p3_q     <= wbc_p3_d;
            pcp4_p3_q    <= pcp4_p3_d;
        end
    end

    assign dmem_req                = req_q;
    assign dmem_we                 = we_q;
    assign dmem_addr               = addr_q;
    assign dmem_wdata              = wdata_q;
    assign dmem_wstrb              = wstrb_q;
    assign mem_stall               = stall;
    assign mem_misaligned          = misaligned_q;
    assign mem_bus_err             = bus_err_q;
    assign mem_fault_addr          = fault_addr_q;
    assign load_data_pype3         = ld_data_q;
    assign ALU_co_pype3            = alu_p3_q;
    assign WReg_pype3              = wreg_p3_q;
    assign writeback_control_pype3 = wbc_p3_q;
    assign PCp4_pype3              = pcp4_p3_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32 pipeline. It consumes the EX/MEM register set (address/ALU result, store data, MemRW, dsize, funct3, writeback controls) and runs the data-memory transaction with a req/ack handshake.
- For stores it builds lane-aligned write data and byte strobes. For loads it selects the byte lane and sign- or zero-extends.
- It drives the pipeline stall while a transaction is outstanding and raises misaligned-access and bus-timeout events. Results go to the MEM/WB register.

Parameters:
- ACK_TIMEOUT, 255: max WAIT cycles before bus error; 0 disables the timeout.
- TMO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ALU_co_pype  in  32  effective address, or ALU result for non-memory instructions
- read_data2_pype2  in  32  store data, low-aligned (EX already masks byte/half)
- MemRW_pype2  in  2  [1]=load, [0]=store; 00=no access
- dsize_pype2  in  2  00 byte, 01 half, 10 word
- funct3_pype2  in  3  load/store funct3 (selects sign/zero extension)
- WReg_pype2  in  5  destination register
- writeback_control_pype2  in  3  writeback control, forwarded
- PCp4_pype2  in  32  PC+4, forwarded
- dmem_req  out  1  request valid, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  lane-replicated write data
- dmem_wstrb  out  4  byte strobes
- dmem_ack  in  1  one-cycle completion
- dmem_rdata  in  32  read word, valid with ack
- mem_stall  out  1  hold IF..EX/MEM registers
- mem_misaligned  out  1  one-cycle pulse
- mem_bus_err  out  1  one-cycle pulse on timeout
- mem_fault_addr  out  32  faulting address
- load_data_pype3  out  32  extended load result
- ALU_co_pype3  out  32  forwarded ALU result
- WReg_pype3  out  5  forwarded destination register
- writeback_control_pype3  out  3  forwarded writeback control
- PCp4_pype3  out  32  forwarded PC+4

Behaviour:
- Reset (rst high at posedge):
  - All outputs and registers go to 0 and the state goes to IDLE.
  - If this happens in WAIT, dmem_req is 0 from the next cycle and the pending response is discarded.
- States: IDLE and WAIT.
- IDLE, MemRW=00:
  - The *_pype3 registers load the inputs and load_data_pype3 loads 0.
  - 1-cycle latency; mem_stall=0.
- IDLE, access requested and aligned:
  - mem_stall=1 combinationally in this cycle.
  - Address, strobes, wdata, funct3, addr[1:0] and the WB fields are latched.
  - dmem_req<=1, dmem_we<=MemRW[0], and the state goes to WAIT.
  - The timeout counter clears.
- Misalignment rules: half with addr[0]=1, or word with addr[1:0]!=00.
- IDLE, misaligned access:
  - No request is issued and there is no stall.
  - mem_misaligned<=1 for one cycle and mem_fault_addr<=address.
  - writeback_control_pype3<=0, so the register write is suppressed.
- WAIT, no ack:
  - dmem_req stays 1 with stable addr/wdata/wstrb/we; mem_stall=1; the counter increments.
- WAIT, counter reaches ACK_TIMEOUT (ACK_TIMEOUT!=0):
  - dmem_req<=0, mem_bus_err pulses, mem_fault_addr<=addr.
  - writeback_control_pype3<=0 and the state returns to IDLE.
  - mem_stall=0 in that cycle.
- WAIT with dmem_ack=1:
  - mem_stall=0 combinationally, so upstream advances this edge.
  - dmem_req<=0 and the WB registers load the latched fields.
  - For a load, load_data_pype3 loads the formatted rdata.
  - State returns to IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- dmem_ack while IDLE is ignored.
- Minimum load latency: inputs at cycle N, req at N+1, ack at N+1, load_data_pype3 valid at N+2.
- Store formatting:
  - SB: wdata = byte replicated ×4, wstrb = 0001<<addr[1:0].
  - SH: wdata = half replicated ×2, wstrb = 0011<<{addr[1],0}.
  - SW: wdata = data, wstrb = 1111.
  - Loads drive wstrb=0000.
- Load formatting: lane = rdata >> 8*addr[1:0].
  - 000 LB sign-extends a byte; 100 LBU zero-extends a byte.
  - 001 LH sign-extends a half; 101 LHU zero-extends a half.
  - 010 LW passes the word; other funct3 codes pass the word.
- When MemRW=11, the access is treated as a load.
- mem_misaligned and mem_bus_err are never asserted simultaneously.

Decomposition:
- Shared package (riscv_mem_pkg):
  - dsize codes.
  - funct3 codes LB/LH/LW/LBU/LHU/SB/SH/SW.
  - MemRW bit indices.
  - State enum IDLE/WAIT.
- One combinational sub-module, mem_lane_align: store replication/strobe generation and load lane-select/extension.
- The FSM, timeout counter and pipeline registers stay in mem_access.

Test Plan:
- LB, addr 0x0000_0103, ack next cycle with rdata 0x80_12_34_56 -> load_data_pype3=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH, addr 0x0000_0102, data 0x0000_BEEF -> dmem_wdata=0xBEEF_BEEF, wstrb=1100, we=1, req held until ack.
- LW, addr 0x0000_0101 -> no dmem_req, mem_misaligned one-cycle pulse, mem_fault_addr=0x101, writeback_control_pype3=0, mem_stall never 1.
- LW, addr 0x200, ack delayed 3 cycles after req -> mem_stall high 4 cycles (start + 3 WAIT), addr stable, result written on the ack edge.
- ACK_TIMEOUT=4, no ack -> req drops after 4 WAIT cycles, mem_bus_err pulses, mem_fault_addr=address, stall releases; a later ack in IDLE is ignored.
- rst asserted during WAIT -> next cycle req=0, stall=0, all *_pype3=0; then an ALU op (MemRW=00) followed by SW back-to-back -> ALU result in 1 cycle, SW issued the following cycle.
